alu_muldiv_unit: RTL and testbench



---
 rtl/alu_muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit. It handles the RV32M-class ALU operation
// codes that the single-cycle ALU cannot complete in one cycle. The latency is
// fixed at WIDTH+1 edges from the accepted start to the registered result.
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   reset           synchronous, active-low reset
//   start_i         request; sampled only while busy_o is low
//   ALU_Operation_i 4-bit operation code, sampled with start_i
//   operand_a_i     rs1 value (multiplicand / dividend)
//   operand_b_i     rs2 value (multiplier / divisor)
//   busy_o          high while an operation is in progress
//   done_o          one-cycle pulse; result_o is valid
//   result_o        result, held until the next operation completes
//   div_by_zero_o   divisor was zero on a div/rem op; held until next done_o
module alu_muldiv_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [3:0]       ALU_Operation_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             div_by_zero_o
);

   localparam int unsigned DW = 2 * WIDTH;

   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULHU = 4'b1001;
   localparam logic [3:0] OP_MULH  = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_REMU  = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_REM   = 4'b1110;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [3:0]       op, op_d;
   logic [DW-1:0]    acc, acc_d;       // product, or {remainder, quotient}
   logic [WIDTH-1:0] opnd, opnd_d;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] raw_a, raw_a_d;   // original dividend for x/0 remainders
   logic             neg, neg_d;       // result must be negated
   logic             b_zero, b_zero_d;
   logic             busy_d, done_d, dbz_d;
   logic [WIDTH-1:0] result_d;

   // Input decode for an accepted start
   logic             in_mul, in_div, in_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign in_mul = (ALU_Operation_i == OP_MUL) || (ALU_Operation_i == OP_MULHU) ||
                   (ALU_Operation_i == OP_MULH);
   assign in_div = (ALU_Operation_i == OP_DIVU) || (ALU_Operation_i == OP_REMU) ||
                   (ALU_Operation_i == OP_DIV)  || (ALU_Operation_i == OP_REM);
   assign in_sgn = (ALU_Operation_i == OP_MULH) || (ALU_Operation_i == OP_DIV) ||
                   (ALU_Operation_i == OP_REM);
   assign a_neg  = in_sgn & operand_a_i[WIDTH-1];
   assign b_neg  = in_sgn & operand_b_i[WIDTH-1];
   // The most-negative value maps onto the unsigned magnitude 2^(WIDTH-1)
   assign mag_a  = a_neg ? -operand_a_i : operand_a_i;
   assign mag_b  = b_neg ? -operand_b_i : operand_b_i;

   // One shift-add multiply step on the product register
   logic             run_mul;
   logic [WIDTH:0]   mul_sum;
   logic [DW-1:0]    mul_next;

   assign run_mul  = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_MULH);
   assign mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, opnd};
   assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[DW-1:1]};

   // One restoring divide step; the remainder always fits WIDTH bits
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] rem_new;
   logic [DW-1:0]    div_next;

   assign div_shift = {acc[DW-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ge    = ~div_diff[WIDTH];
   assign rem_new   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {rem_new, acc[WIDTH-2:0], div_ge};

   // Final sign correction and special-case selection
   logic [DW-1:0]    acc_neg;
   logic [WIDTH-1:0] quo, rem, fix_res;
   logic             fix_dbz;

   assign acc_neg = -acc;
   assign quo     = acc[WIDTH-1:0];
   assign rem     = acc[DW-1:WIDTH];

   always_comb begin
      fix_res = '0;
      fix_dbz = 1'b0;
      case (op)
         OP_MUL:   fix_res = quo;
         OP_MULHU: fix_res = rem;
         OP_MULH:  fix_res = neg ? acc_neg[DW-1:WIDTH] : rem;
         OP_DIVU:  begin
            fix_dbz = b_zero;
            fix_res = b_zero ? '1 : quo;
         end
         OP_REMU:  begin
            fix_dbz = b_zero;
            fix_res = b_zero ? raw_a : rem;
         end
         OP_DIV:   begin
            fix_dbz = b_zero;
            fix_res = b_zero ? '1 : (neg ? -quo : quo);
         end
         OP_REM:   begin
            fix_dbz = b_zero;
            fix_res = b_zero ? raw_a : (neg ? -rem : rem);
         end
         default:  fix_res = '0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      op_d     = op;
      acc_d    = acc;
      opnd_d   = opnd;
      raw_a_d  = raw_a;
      neg_d    = neg;
      b_zero_d = b_zero;
      busy_d   = busy_o;
      done_d   = 1'b0;
      dbz_d    = div_by_zero_o;
      result_d = result_o;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_d  = RUN;
               cnt_d    = CNT_W'(WIDTH - 1);
               op_d     = ALU_Operation_i;
               acc_d    = {{WIDTH{1'b0}}, (in_mul ? mag_b : mag_a)};
               opnd_d   = in_mul ? mag_a : mag_b;
               raw_a_d  = operand_a_i;
               neg_d    = (ALU_Operation_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
               b_zero_d = in_div && (operand_b_i == '0);
               busy_d   = 1'b1;
            end
         end
         RUN: begin
            acc_d = run_mul ? mul_next : div_next;
            if (cnt == '0) state_d = FIX;
            else           cnt_d   = cnt - CNT_W'(1);
         end
         FIX: begin
            state_d  = IDLE;
            result_d = fix_res;
            dbz_d    = fix_dbz;
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         op            <= '0;
         acc           <= '0;
         opnd          <= '0;
         raw_a         <= '0;
         neg           <= 1'b0;
         b_zero        <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         result_o      <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         op            <= op_d;
         acc           <= acc_d;
         opnd          <= opnd_d;
         raw_a         <= raw_a_d;
         neg           <= neg_d;
         b_zero        <= b_zero_d;
         busy_o        <= busy_d;
         done_o        <= done_d;
         result_o      <= result_d;
         div_by_zero_o <= dbz_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
`timescale 1ns/1ps
// Directed bench for alu_muldiv_unit: hand-computed vectors, fixed latency,
// divide-by-zero and overflow cases, start-while-busy, back-to-back, reset.
module tb_alu_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [3:0]  ALU_Operation_i;
   logic [31:0] operand_a_i, operand_b_i;
   logic        busy_o, done_o, div_by_zero_o;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

   alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .ALU_Operation_i (ALU_Operation_i),
      .operand_a_i     (operand_a_i),
      .operand_b_i     (operand_b_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .result_o        (result_o),
      .div_by_zero_o   (div_by_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; counts edges until done_o is seen (bounded)
   task automatic wait_done(output int n);
      n = 0;
      while (!done_o && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_dbz);
      int n;
      @(negedge clk);
      start_i = 1'b1; ALU_Operation_i = op; operand_a_i = a; operand_b_i = b;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0; operand_a_i = 32'hDEAD_BEEF; operand_b_i = 32'h1234_5678;
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      wait_done(n);
      check({tag, "_lat"}, 32'(n), 32'd33);
      check({tag, "_res"}, result_o, exp);
      check({tag, "_dbz"}, 32'(div_by_zero_o), 32'(exp_dbz));
      check({tag, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int n, n2, dones;
      reset = 1'b0; start_i = 1'b0; ALU_Operation_i = '0; operand_a_i = '0; operand_b_i = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_res",  result_o, 32'd0);
      check("rst_dbz",  32'(div_by_zero_o), 32'd0);
      reset = 1'b1;

      do_op("mul",      4'b1000, 32'd7,        32'd6,        32'd42,         1'b0);
      do_op("mulhu",    4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   1'b0);
      do_op("mulh_m1",  4'b1010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,   1'b0);
      do_op("mulh_mn2", 4'b1010, 32'h80000000, 32'h80000000, 32'h40000000,   1'b0);
      do_op("mulh_mn1", 4'b1010, 32'h80000000, 32'd1,        32'hFFFFFFFF,   1'b0);
      do_op("divu",     4'b1011, 32'd100,      32'd7,        32'd14,         1'b0);
      do_op("remu",     4'b1100, 32'd100,      32'd7,        32'd2,          1'b0);
      do_op("div_n",    4'b1101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   1'b0);
      do_op("rem_n",    4'b1110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   1'b0);
      do_op("div_nd",   4'b1101, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,   1'b0);
      do_op("rem_nd",   4'b1110, 32'd7,        32'hFFFFFFFE, 32'd1,          1'b0);
      do_op("divu_z",   4'b1011, 32'd5,        32'd0,        32'hFFFFFFFF,   1'b1);
      // div_by_zero_o holds after the done pulse
      repeat (2) @(negedge clk);
      check("dbz_hold", 32'(div_by_zero_o), 32'd1);
      do_op("rem_z",    4'b1110, 32'd5,        32'd0,        32'd5,          1'b1);
      do_op("rem_zn",   4'b1110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9,   1'b1);
      do_op("div_zn",   4'b1101, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF,   1'b1);
      do_op("div_ovf",  4'b1101, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   1'b0);
      do_op("rem_ovf",  4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0,          1'b0);
      do_op("unsup",    4'b0011, 32'd9,        32'd3,        32'd0,          1'b0);
      do_op("remu_z",   4'b1100, 32'd77,       32'd0,        32'd77,         1'b1);

      // start while busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      start_i = 1'b1; ALU_Operation_i = 4'b1000; operand_a_i = 32'd3; operand_b_i = 32'd5;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) begin @(posedge clk); @(negedge clk); end
      start_i = 1'b1; ALU_Operation_i = 4'b1011; operand_a_i = 32'd9; operand_b_i = 32'd0;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      wait_done(n);
      check("ign_lat", 32'(n + 5), 32'd33);
      check("ign_res", result_o, 32'd15);
      check("ign_dbz", 32'(div_by_zero_o), 32'd0);
      start_i = 1'b1; ALU_Operation_i = 4'b1001; operand_a_i = 32'hFFFFFFFF; operand_b_i = 32'd2;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      check("b2b_busy", 32'(busy_o), 32'd1);
      wait_done(n2);
      check("b2b_lat", 32'(n2 + 1), 32'd34);
      check("b2b_res", result_o, 32'd1);

      // reset mid-operation aborts with no done pulse
      @(negedge clk);
      start_i = 1'b1; ALU_Operation_i = 4'b1000; operand_a_i = 32'd11; operand_b_i = 32'd13;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mrst_busy", 32'(busy_o), 32'd0);
      check("mrst_res",  result_o, 32'd0);
      check("mrst_dbz",  32'(div_by_zero_o), 32'd0);
      reset = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      check("mrst_nodone", 32'(dones), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
